inst_decode_queue: RTL and testbench

//  Instruction queue between fetch and decode. Accepts up to FETCH_W instruction words per cycle and predecodes each word at enqueue.

---
 rtl/idq_pkg.sv | 95 +++++++++
 rtl/idq_predecode.sv | 89 ++++++++
 rtl/inst_decode_queue.sv | 148 ++++++++++++++
 tb/tb_inst_decode_queue.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/idq_pkg.sv
// Shared types and MIPS32 encoding constants for the instruction decode queue.
package idq_pkg;

  typedef enum logic [3:0] {
    CLS_ALU_R  = 4'd0,
    CLS_SHIFT  = 4'd1,
    CLS_ALU_I  = 4'd2,
    CLS_LOAD   = 4'd3,
    CLS_STORE  = 4'd4,
    CLS_BRANCH = 4'd5,
    CLS_JUMP   = 4'd6,
    CLS_FPU    = 4'd7,
    CLS_FMEM   = 4'd8,
    CLS_CP0    = 4'd9,
    CLS_SYS    = 4'd10,
    CLS_NOP    = 4'd11,
    CLS_UNIMPL = 4'd12
  } cls_e;

  typedef enum logic [5:0] {
    ID_NONE    = 6'd0,
    ID_NOP     = 6'd1,
    ID_ADD     = 6'd2,
    ID_SUB     = 6'd3,
    ID_AND     = 6'd4,
    ID_OR      = 6'd5,
    ID_XOR     = 6'd6,
    ID_SLL     = 6'd7,
    ID_SRL     = 6'd8,
    ID_SRA     = 6'd9,
    ID_JR      = 6'd10,
    ID_SYSCALL = 6'd11,
    ID_ADDI    = 6'd12,
    ID_ANDI    = 6'd13,
    ID_ORI     = 6'd14,
    ID_XORI    = 6'd15,
    ID_LUI     = 6'd16,
    ID_LW      = 6'd17,
    ID_SW      = 6'd18,
    ID_BEQ     = 6'd19,
    ID_BNE     = 6'd20,
    ID_J       = 6'd21,
    ID_JAL     = 6'd22,
    ID_LWC1    = 6'd23,
    ID_SWC1    = 6'd24,
    ID_FADD    = 6'd25,
    ID_FSUB    = 6'd26,
    ID_FMUL    = 6'd27,
    ID_FDIV    = 6'd28,
    ID_FSQRT   = 6'd29,
    ID_MFC0    = 6'd30,
    ID_MTC0    = 6'd31,
    ID_ERET    = 6'd32
  } op_id_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_COP1    = 6'h11;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_LWC1    = 6'h31;
  localparam logic [5:0] OP_SWC1    = 6'h39;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;

  localparam logic [5:0] FP_ADD     = 6'h00;
  localparam logic [5:0] FP_SUB     = 6'h01;
  localparam logic [5:0] FP_MUL     = 6'h02;
  localparam logic [5:0] FP_DIV     = 6'h03;
  localparam logic [5:0] FP_SQRT    = 6'h04;

  localparam logic [4:0] CP0_MF     = 5'h00;
  localparam logic [4:0] CP0_MT     = 5'h04;
  localparam logic [4:0] CP0_CO     = 5'h10;
  localparam logic [5:0] FN_ERET    = 6'h18;

endpackage

// File: rtl/idq_predecode.sv
// Combinational predecoder: one MIPS32 word -> {class, instruction ID, unimplemented flag}.
module idq_predecode
  import idq_pkg::*;
(
  input  logic [31:0] inst,
  output logic [3:0]  cls,
  output logic [5:0]  op_id,
  output logic        unimpl
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  cls_e       c;
  op_id_e     id;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign funct = inst[5:0];

  always_comb begin
    c  = CLS_UNIMPL;
    id = ID_NONE;
    // The all-zero word is the canonical nop and must win over sll $0,$0,0
    if (inst == 32'h0) begin
      c  = CLS_NOP;
      id = ID_NOP;
    end else begin
      case (op)
        OP_SPECIAL: begin
          case (funct)
            FN_ADD:     begin c = CLS_ALU_R; id = ID_ADD;     end
            FN_SUB:     begin c = CLS_ALU_R; id = ID_SUB;     end
            FN_AND:     begin c = CLS_ALU_R; id = ID_AND;     end
            FN_OR:      begin c = CLS_ALU_R; id = ID_OR;      end
            FN_XOR:     begin c = CLS_ALU_R; id = ID_XOR;     end
            FN_SLL:     begin c = CLS_SHIFT; id = ID_SLL;     end
            FN_SRL:     begin c = CLS_SHIFT; id = ID_SRL;     end
            FN_SRA:     begin c = CLS_SHIFT; id = ID_SRA;     end
            FN_JR:      begin c = CLS_JUMP;  id = ID_JR;      end
            FN_SYSCALL: begin c = CLS_SYS;   id = ID_SYSCALL; end
            default:    ;
          endcase
        end
        OP_ADDI: begin c = CLS_ALU_I;  id = ID_ADDI; end
        OP_ANDI: begin c = CLS_ALU_I;  id = ID_ANDI; end
        OP_ORI:  begin c = CLS_ALU_I;  id = ID_ORI;  end
        OP_XORI: begin c = CLS_ALU_I;  id = ID_XORI; end
        OP_LUI:  begin c = CLS_ALU_I;  id = ID_LUI;  end
        OP_LW:   begin c = CLS_LOAD;   id = ID_LW;   end
        OP_SW:   begin c = CLS_STORE;  id = ID_SW;   end
        OP_BEQ:  begin c = CLS_BRANCH; id = ID_BEQ;  end
        OP_BNE:  begin c = CLS_BRANCH; id = ID_BNE;  end
        OP_J:    begin c = CLS_JUMP;   id = ID_J;    end
        OP_JAL:  begin c = CLS_JUMP;   id = ID_JAL;  end
        OP_LWC1: begin c = CLS_FMEM;   id = ID_LWC1; end
        OP_SWC1: begin c = CLS_FMEM;   id = ID_SWC1; end
        OP_COP1: begin
          case (funct)
            FP_ADD:  begin c = CLS_FPU; id = ID_FADD;  end
            FP_SUB:  begin c = CLS_FPU; id = ID_FSUB;  end
            FP_MUL:  begin c = CLS_FPU; id = ID_FMUL;  end
            FP_DIV:  begin c = CLS_FPU; id = ID_FDIV;  end
            FP_SQRT: begin c = CLS_FPU; id = ID_FSQRT; end
            default: ;
          endcase
        end
        OP_COP0: begin
          if (rs == CP0_MF) begin
            c  = CLS_CP0;
            id = ID_MFC0;
          end else if (rs == CP0_MT) begin
            c  = CLS_CP0;
            id = ID_MTC0;
          end else if (rs == CP0_CO && funct == FN_ERET) begin
            c  = CLS_CP0;
            id = ID_ERET;
          end
        end
        default: ;
      endcase
    end
  end

  assign cls    = c;
  assign op_id  = id;
  assign unimpl = (c == CLS_UNIMPL);

endmodule

// File: rtl/inst_decode_queue.sv
// Fetch->decode instruction queue with predecode at enqueue.
// Optional IDQ_UNIMPL_TRAP_EN: popping an unimplemented word blocks the head until flush/rst.
module inst_decode_queue
  import idq_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [32*FETCH_W-1:0]        in_inst,
  input  logic [31:0]                  in_pc,
  input  logic [$clog2(FETCH_W+1)-1:0] in_cnt,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_inst,
  output logic [31:0]                  out_pc,
  output logic [3:0]                   out_class,
  output logic [5:0]                   out_op_id,
  output logic                         out_unimpl,
  output logic [4:0]                   out_rs,
  output logic [4:0]                   out_rt,
  output logic [4:0]                   out_rd,
  output logic [4:0]                   out_sa,
  output logic [15:0]                  out_imm,
  output logic [$clog2(DEPTH):0]       occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(FETCH_W + 1);

  logic [31:0]        inst_mem   [DEPTH];
  logic [31:0]        pc_mem     [DEPTH];
  logic [3:0]         cls_mem    [DEPTH];
  logic [5:0]         id_mem     [DEPTH];
  logic [DEPTH-1:0]   unimpl_mem;

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [OCC_W-1:0]   occ;
  logic               trap;
  logic               has_entry;
  logic               do_push, do_pop;
  logic [CNT_W-1:0]   n_req, n_push;

  logic [31:0]        lane_inst [FETCH_W];
  logic [31:0]        lane_pc   [FETCH_W];
  logic [3:0]         lane_cls  [FETCH_W];
  logic [5:0]         lane_id   [FETCH_W];
  logic [FETCH_W-1:0] lane_unimpl;

  logic [31:0]        last_inst, last_pc;
  logic [3:0]         last_cls;
  logic [5:0]         last_id;
  logic               last_unimpl;

  for (genvar g = 0; g < FETCH_W; g++) begin : g_lane
    assign lane_inst[g] = in_inst[32*g +: 32];
    assign lane_pc[g]   = in_pc + 32'(4 * g);

    idq_predecode u_predecode (
      .inst   (lane_inst[g]),
      .cls    (lane_cls[g]),
      .op_id  (lane_id[g]),
      .unimpl (lane_unimpl[g])
    );
  end

  // Handshakes depend only on registered occupancy/trap state
  assign has_entry = (occ != '0);
  assign in_ready  = (OCC_W'(DEPTH) - occ) >= OCC_W'(FETCH_W);
  assign out_valid = has_entry && !trap;

  assign n_req   = (in_cnt > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : in_cnt;
  assign do_push = in_valid && in_ready && !flush;
  assign do_pop  = out_valid && out_ready;
  assign n_push  = do_push ? n_req : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      rd_ptr <= rd_ptr + PTR_W'(do_pop);
      occ    <= occ + OCC_W'(n_push) - OCC_W'(do_pop);
    end
  end

`ifdef IDQ_UNIMPL_TRAP_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      trap <= 1'b0;
    end else if (do_pop && unimpl_mem[rd_ptr]) begin
      trap <= 1'b1;
    end
  end
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    for (int i = 0; i < FETCH_W; i++) begin
      if (CNT_W'(i) < n_push) begin
        inst_mem[wr_ptr + PTR_W'(i)]   <= lane_inst[i];
        pc_mem[wr_ptr + PTR_W'(i)]     <= lane_pc[i];
        cls_mem[wr_ptr + PTR_W'(i)]    <= lane_cls[i];
        id_mem[wr_ptr + PTR_W'(i)]     <= lane_id[i];
        unimpl_mem[wr_ptr + PTR_W'(i)] <= lane_unimpl[i];
      end
    end
  end

  // Holds the most recently popped entry so outputs stay stable while empty
  always_ff @(posedge clk) begin
    if (rst) begin
      last_inst   <= '0;
      last_pc     <= '0;
      last_cls    <= '0;
      last_id     <= '0;
      last_unimpl <= 1'b0;
    end else if (do_pop && !flush) begin
      last_inst   <= inst_mem[rd_ptr];
      last_pc     <= pc_mem[rd_ptr];
      last_cls    <= cls_mem[rd_ptr];
      last_id     <= id_mem[rd_ptr];
      last_unimpl <= unimpl_mem[rd_ptr];
    end
  end

  assign out_inst   = has_entry ? inst_mem[rd_ptr]   : last_inst;
  assign out_pc     = has_entry ? pc_mem[rd_ptr]     : last_pc;
  assign out_class  = has_entry ? cls_mem[rd_ptr]    : last_cls;
  assign out_op_id  = has_entry ? id_mem[rd_ptr]     : last_id;
  assign out_unimpl = has_entry ? unimpl_mem[rd_ptr] : last_unimpl;

  assign out_rs    = out_inst[25:21];
  assign out_rt    = out_inst[20:16];
  assign out_rd    = out_inst[15:11];
  assign out_sa    = out_inst[10:6];
  assign out_imm   = out_inst[15:0];
  assign occupancy = occ;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Scoreboard bench for inst_decode_queue (DEPTH=8, FETCH_W=2).
module tb_inst_decode_queue;
  import idq_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_inst;
  logic [31:0] in_pc, out_inst, out_pc;
  logic [1:0]  in_cnt;
  logic [3:0]  out_class;
  logic [5:0]  out_op_id;
  logic        out_unimpl;
  logic [4:0]  out_rs, out_rt, out_rd, out_sa;
  logic [15:0] out_imm;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  inst_decode_queue #(.DEPTH(DEPTH), .FETCH_W(FW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .in_cnt(in_cnt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_class(out_class),
    .out_op_id(out_op_id), .out_unimpl(out_unimpl),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_sa(out_sa),
    .out_imm(out_imm), .occupancy(occupancy)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [5:0]  id;
  } ent_t;

  ent_t        sb[$];
  ent_t        last;
  bit          trap_m;
  int          n_cmp = 0;
  int          n_err = 0;

  // Hand-decoded reference words
  logic [31:0] tw [16];
  logic [3:0]  tc [16];
  logic [5:0]  ti [16];

  task automatic set_word(input int k, input logic [31:0] w, input logic [3:0] c,
                          input logic [5:0] id);
    tw[k] = w; tc[k] = c; ti[k] = id;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    ent_t h;
    int   sz;
    sz = sb.size();
    h  = (sz > 0) ? sb[0] : last;
    check_eq("occupancy", 32'(occupancy), 32'(sz));
    check_eq("in_ready", 32'(in_ready), 32'((DEPTH - sz) >= FW));
    check_eq("out_valid", 32'(out_valid), 32'(sz > 0 && !trap_m));
    check_eq("out_inst", out_inst, h.inst);
    check_eq("out_pc", out_pc, h.pc);
    check_eq("out_class", 32'(out_class), 32'(h.cls));
    check_eq("out_op_id", 32'(out_op_id), 32'(h.id));
    check_eq("out_unimpl", 32'(out_unimpl), 32'(h.cls == CLS_UNIMPL));
    check_eq("out_rs", 32'(out_rs), 32'(h.inst[25:21]));
    check_eq("out_rt", 32'(out_rt), 32'(h.inst[20:16]));
    check_eq("out_rd", 32'(out_rd), 32'(h.inst[15:11]));
    check_eq("out_sa", 32'(out_sa), 32'(h.inst[10:6]));
    check_eq("out_imm", 32'(out_imm), 32'(h.inst[15:0]));
  endtask

  // One clock: check current outputs, drive inputs, advance the model
  task automatic cycle(input bit r, input bit fl, input bit v, input int a, input int b,
                       input logic [31:0] pc, input int cnt, input bit rdy);
    bit   mv, mr;
    int   n;
    ent_t e;
    check_state();
    rst = r; flush = fl; in_valid = v; out_ready = rdy;
    in_inst = {tw[b], tw[a]};
    in_pc   = pc;
    in_cnt  = 2'(cnt);
    mv = (sb.size() > 0) && !trap_m;
    mr = (DEPTH - sb.size()) >= FW;
    if (r) begin
      sb.delete();
      last.inst = '0; last.pc = '0; last.cls = '0; last.id = '0;
      trap_m = 1'b0;
    end else if (fl) begin
      sb.delete();
      trap_m = 1'b0;
    end else begin
      if (mv && rdy) begin
        last = sb.pop_front();
`ifdef IDQ_UNIMPL_TRAP_EN
        if (last.cls == CLS_UNIMPL) trap_m = 1'b1;
`endif
      end
      n = (cnt > FW) ? FW : cnt;
      if (v && mr) begin
        for (int i = 0; i < n; i++) begin
          int k;
          k = (i == 0) ? a : b;
          e.inst = tw[k]; e.pc = pc + 32'(4 * i); e.cls = tc[k]; e.id = ti[k];
          sb.push_back(e);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 32'h0, 0, rdy);
  endtask

  task automatic push(input int a, input int b, input logic [31:0] pc, input int cnt,
                      input bit rdy);
    cycle(1'b0, 1'b0, 1'b1, a, b, pc, cnt, rdy);
  endtask

  initial begin
    set_word(0,  32'h01095020, CLS_ALU_R,  ID_ADD);
    set_word(1,  32'h8FA80004, CLS_LOAD,   ID_LW);
    set_word(2,  32'h00000000, CLS_NOP,    ID_NOP);
    set_word(3,  32'h00000018, CLS_UNIMPL, ID_NONE);
    set_word(4,  32'h0000000C, CLS_SYS,    ID_SYSCALL);
    set_word(5,  32'h42000018, CLS_CP0,    ID_ERET);
    set_word(6,  32'h46041000, CLS_FPU,    ID_FADD);
    set_word(7,  32'h00021080, CLS_SHIFT,  ID_SLL);
    set_word(8,  32'hAFA90008, CLS_STORE,  ID_SW);
    set_word(9,  32'h1109FFFE, CLS_BRANCH, ID_BEQ);
    set_word(10, 32'h0C000040, CLS_JUMP,   ID_JAL);
    set_word(11, 32'h40886000, CLS_CP0,    ID_MTC0);
    set_word(12, 32'hC7A00010, CLS_FMEM,   ID_LWC1);
    set_word(13, 32'h3C011234, CLS_ALU_I,  ID_LUI);
    set_word(14, 32'h03E00008, CLS_JUMP,   ID_JR);
    set_word(15, 32'hFC000000, CLS_UNIMPL, ID_NONE);

    last.inst = '0; last.pc = '0; last.cls = '0; last.id = '0;
    trap_m = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; in_cnt = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // add, single lane
    push(0, 0, 32'h200, 1, 1'b0);
    check_eq("t1_class", 32'(out_class), 32'(CLS_ALU_R));
    check_eq("t1_rs", 32'(out_rs), 32'd8);
    check_eq("t1_rt", 32'(out_rt), 32'd9);
    check_eq("t1_rd", 32'(out_rd), 32'd10);
    check_eq("t1_unimpl", 32'(out_unimpl), 32'd0);
    idle(1'b1);

    // lw + nop in one group
    push(1, 2, 32'h100, 2, 1'b0);
    check_eq("t2_class", 32'(out_class), 32'(CLS_LOAD));
    check_eq("t2_imm", 32'(out_imm), 32'd4);
    check_eq("t2_pc", out_pc, 32'h100);
    idle(1'b1);
    check_eq("t2_nop_class", 32'(out_class), 32'(CLS_NOP));
    check_eq("t2_nop_pc", out_pc, 32'h104);
    idle(1'b1);
    idle(1'b0);

    // fill, full back-pressure, simultaneous push/pop near full
    push(7, 8, 32'h1000, 2, 1'b0);
    push(9, 10, 32'h1008, 2, 1'b0);
    push(11, 12, 32'h1010, 2, 1'b0);
    push(13, 14, 32'h1018, 2, 1'b0);
    check_eq("t3_full_ready", 32'(in_ready), 32'd0);
    check_eq("t3_full_occ", 32'(occupancy), 32'd8);
    push(0, 1, 32'h2000, 2, 1'b1);
    push(4, 4, 32'h2000, 1, 1'b1);
    for (int c = 0; c < 60; c++) begin
      push(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
           32'h3000 + 32'(16 * c), int'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 10; c++) idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 0, 1'b0);

    // unimplemented word at the head
    push(3, 0, 32'h4000, 2, 1'b0);
    push(4, 5, 32'h4008, 2, 1'b0);
    check_eq("t4_unimpl", 32'(out_unimpl), 32'd1);
    check_eq("t4_class", 32'(out_class), 32'(CLS_UNIMPL));
    check_eq("t4_op_id", 32'(out_op_id), 32'(ID_NONE));
    idle(1'b1);
`ifdef IDQ_UNIMPL_TRAP_EN
    check_eq("t4_trap_valid", 32'(out_valid), 32'd0);
`else
    check_eq("t4_flow_valid", 32'(out_valid), 32'd1);
`endif
    idle(1'b1);
    idle(1'b1);
    cycle(1'b0, 1'b1, 1'b0, 0, 0, 32'h0, 0, 1'b0);

    // flush with a simultaneous push at occupancy 5
    push(0, 1, 32'h5000, 2, 1'b0);
    push(2, 7, 32'h5008, 2, 1'b0);
    push(8, 8, 32'h5010, 1, 1'b0);
    check_eq("t5_occ5", 32'(occupancy), 32'd5);
    cycle(1'b0, 1'b1, 1'b1, 9, 10, 32'h5020, 2, 1'b1);
    check_eq("t5_occ0", 32'(occupancy), 32'd0);
    check_eq("t5_valid", 32'(out_valid), 32'd0);

    // special encodings, in_cnt=0 no-op, in_cnt clamp
    push(4, 5, 32'h6000, 2, 1'b0);
    check_eq("t6_sys", 32'(out_class), 32'(CLS_SYS));
    push(6, 11, 32'h6008, 3, 1'b0);
    push(0, 1, 32'h6010, 0, 1'b0);
    check_eq("t6_cnt0_occ", 32'(occupancy), 32'd4);
    idle(1'b1);
    check_eq("t6_eret_id", 32'(out_op_id), 32'(ID_ERET));
    idle(1'b1);
    check_eq("t6_fadd_id", 32'(out_op_id), 32'(ID_FADD));

    // reset mid-stream drops everything
    push(13, 14, 32'h7000, 2, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 0, 1, 32'h7100, 2, 1'b1);
    check_eq("t7_rst_occ", 32'(occupancy), 32'd0);
    check_eq("t7_rst_inst", out_inst, 32'h0);
    push(12, 12, 32'h8000, 1, 1'b0);
    idle(1'b1);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
